commit_perf_monitor: RTL and testbench
======================================

// Module: commit_perf_monitor
// PURPOSE
//   Sits directly downstream of the pipelined core's commit/debug outputs (insn_vld, ctrl, mispred, pc_debug, hazard flag).
//   Accumulates per-run performance counters, records the PCs of mispredicted control transfers in a small FIFO,
//   and flags a hang when nothing retires for too long. The scoreboard reads results over a 1-cycle registered read port.
// PARAMETERS
//   CNT_W        32    width of each event counter (saturating)
//   TRACE_DEPTH  8     mispredict-PC FIFO entries, power of 2, >=2
//   HANG_LIMIT   1024  consecutive non-retiring cycles before o_hang asserts
// PORTS
//   i_clk        in   1           core clock
//   i_reset      in   1           asynchronous, active-low reset
//   i_enable     in   1           counting enable; 0 freezes all counters and the hang timer
//   i_clear      in   1           synchronous clear of counters, FIFO, flags; FSM -> IDLE
//   i_insn_vld   in   1           an instruction retires this cycle
//   i_ctrl       in   1           retiring insn is branch/jump (qualified by i_insn_vld)
//   i_mispred    in   1           retiring insn was mispredicted (qualified by i_insn_vld)
//   i_pc         in   32          PC of retiring insn
//   i_stall      in   1           data-hazard stall asserted this cycle
//   i_rd_addr    in   3           counter/status select
//   o_rd_data    out  32          registered read data, 1-cycle latency
//   i_trace_pop  in   1           pop FIFO head
//   o_trace_vld  out  1           FIFO non-empty
//   o_trace_pc   out  32          FIFO head (first-word fall-through)
//   o_trace_ovf  out  1           sticky: a mispredict PC was dropped (FIFO full)
//   o_hang       out  1           sticky hang flag
// BEHAVIOUR
//   Reset (i_reset=0, async): all counters 0, FIFO empty, o_rd_data=0, o_trace_vld=0, o_trace_pc=0, o_trace_ovf=0, o_hang=0, FSM=IDLE.
//   FSM: IDLE -> RUN on first cycle with i_enable & i_insn_vld; that cycle is counted.
//        RUN -> HUNG when hang timer reaches HANG_LIMIT; HUNG is sticky (o_hang=1) until i_clear or reset.
//        Any state -> IDLE on i_clear; i_clear has priority over every increment and push in the same cycle.
//   Counting (RUN/HUNG, plus the IDLE->RUN cycle, only when i_enable=1):
//     cycles += 1; retired += i_insn_vld; ctrl += i_insn_vld&i_ctrl;
//     mispred += i_insn_vld&i_mispred; stall += i_stall.
//     All counters saturate at 2^CNT_W-1; never wrap.
//   Hang timer: resets to 0 on any retire; otherwise +1 per enabled RUN cycle; o_hang rises the cycle after it equals HANG_LIMIT.
//   FIFO push: i_insn_vld & i_mispred while counting. Full & push & !pop -> drop, set o_trace_ovf.
//     Full & push & pop -> both succeed, no overflow. Pop when empty is ignored. Pop is honoured even when i_enable=0.
//   Read map (o_rd_data <= value at cycle of request; pre-increment when a counter updates that same cycle):
//     0 cycles, 1 retired, 2 ctrl, 3 mispred, 4 stall (zero-extended/truncated to 32),
//     5 status {20'b0, fifo_count[7:0], ovf, hang, state[1:0]}, 6-7 return 0.
//   State encoding: IDLE=0, RUN=1, HUNG=2.
// STRUCTURE
//   perf_pkg: perf_state_e enum; RD_* address localparams; status field offsets.
//   Sub-module mispred_trace_fifo (sync FWFT FIFO, DEPTH, WIDTH=32, push/pop/full/empty/count) holds the PC trace.
//   Top level: FSM, five saturating counters, hang timer, read mux register.
// TESTING
//   1. Reset, enable, 10 retires 1/cycle, no ctrl -> rd 0 = 10, rd 1 = 10, rd 5 state = RUN, o_hang = 0.
//   2. 3 mispredicts at pc 0x100/0x104/0x108 -> rd 3 = 3; pops return 0x100, 0x104, 0x108 in order; o_trace_vld then 0.
//   3. TRACE_DEPTH+1 mispredicts, no pop -> count = 8, o_trace_ovf = 1.
//      Repeat with push & pop in the same cycle while full -> ovf stays 0.
//   4. Retire once, then HANG_LIMIT=16 idle cycles -> o_hang = 1, state = HUNG.
//      A later retire keeps o_hang = 1; i_clear -> o_hang = 0, state = IDLE, counters = 0.
//   5. Preload counters near saturation (CNT_W=4): 20 retires -> rd 1 = 15 (saturated, no wrap).
//   6. Async reset asserted mid-run between clock edges -> all outputs 0 immediately.
//      i_clear asserted with i_insn_vld & i_mispred in the same cycle -> counters 0, FIFO empty.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the commit-stage performance monitor.
// Covers the FSM state encoding, the read-port address map and the status word layout.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HUNG = 2'd2
  } perf_state_e;

  localparam logic [2:0] RD_CYCLES  = 3'd0;
  localparam logic [2:0] RD_RETIRED = 3'd1;
  localparam logic [2:0] RD_CTRL    = 3'd2;
  localparam logic [2:0] RD_MISPRED = 3'd3;
  localparam logic [2:0] RD_STALL   = 3'd4;
  localparam logic [2:0] RD_STATUS  = 3'd5;

  // Status word: {20'b0, fifo_count[7:0], ovf, hang, state[1:0]}
  localparam int ST_STATE_LSB = 0;
  localparam int ST_HANG_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;

endpackage

// File: rtl/mispred_trace_fifo.sv
// Synchronous first-word-fall-through FIFO holding mispredicted-branch PCs.
// Push and pop may both succeed while the FIFO is full; the head reads as zero when empty.
module mispred_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = o_empty ? '0 : r_mem[r_rd];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= r_rd + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/commit_perf_monitor.sv
// Commit-stage performance monitor: saturating event counters, mispredict PC trace,
// hang detection and a registered one-cycle read port for the scoreboard.
module commit_perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 8,
  parameter int HANG_LIMIT  = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_clear,
  input  logic        i_insn_vld,
  input  logic        i_ctrl,
  input  logic        i_mispred,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic [2:0]  i_rd_addr,
  output logic [31:0] o_rd_data,
  input  logic        i_trace_pop,
  output logic        o_trace_vld,
  output logic [31:0] o_trace_pc,
  output logic        o_trace_ovf,
  output logic        o_hang
);

  localparam int TW = $clog2(HANG_LIMIT + 1);

  perf_state_e                  r_state;
  logic [CNT_W-1:0]             r_cyc, r_ret, r_ctrl, r_misp, r_stall;
  logic [TW-1:0]                r_timer;
  logic                         r_hang, r_ovf;
  logic                         w_counting, w_push, w_pop, w_full, w_empty;
  logic [$clog2(TRACE_DEPTH):0] w_count;
  logic [31:0]                  w_status;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    else return v;
  endfunction

  // The IDLE->RUN cycle itself is counted, hence the retire term.
  assign w_counting = i_enable && ((r_state != ST_IDLE) || i_insn_vld);
  assign w_push     = !i_clear && w_counting && i_insn_vld && i_mispred;
  assign w_pop      = !i_clear && i_trace_pop;
  assign w_status   = {20'd0, 8'(w_count), r_ovf, r_hang, r_state};

  mispred_trace_fifo #(.DEPTH(TRACE_DEPTH), .WIDTH(32)) u_trace (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_pc),
    .o_dout  (o_trace_pc),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_trace_vld = !w_empty;
  assign o_trace_ovf = r_ovf;
  assign o_hang      = r_hang;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_ret   <= '0;
      r_ctrl  <= '0;
      r_misp  <= '0;
      r_stall <= '0;
      r_timer <= '0;
      r_hang  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_ret   <= '0;
      r_ctrl  <= '0;
      r_misp  <= '0;
      r_stall <= '0;
      r_timer <= '0;
      r_hang  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_counting) begin
        r_cyc   <= sat_inc(r_cyc, 1'b1);
        r_ret   <= sat_inc(r_ret, i_insn_vld);
        r_ctrl  <= sat_inc(r_ctrl, i_insn_vld & i_ctrl);
        r_misp  <= sat_inc(r_misp, i_insn_vld & i_mispred);
        r_stall <= sat_inc(r_stall, i_stall);
      end
      // A push into a full FIFO is lost unless a pop frees the slot this cycle.
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_enable && i_insn_vld) begin
            r_state <= ST_RUN;
            r_timer <= '0;
          end
        end
        ST_RUN: begin
          if (r_timer == TW'(HANG_LIMIT)) begin
            r_state <= ST_HUNG;
            r_hang  <= 1'b1;
          end else if (i_enable) begin
            r_timer <= i_insn_vld ? '0 : r_timer + TW'(1);
          end
        end
        ST_HUNG: r_hang  <= 1'b1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read port samples the pre-update values of the requested cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rd_data <= 32'd0;
    end else begin
      case (i_rd_addr)
        RD_CYCLES:  o_rd_data <= 32'(r_cyc);
        RD_RETIRED: o_rd_data <= 32'(r_ret);
        RD_CTRL:    o_rd_data <= 32'(r_ctrl);
        RD_MISPRED: o_rd_data <= 32'(r_misp);
        RD_STALL:   o_rd_data <= 32'(r_stall);
        RD_STATUS:  o_rd_data <= w_status;
        default:    o_rd_data <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_perf_monitor.sv
// Bench for commit_perf_monitor: a 32-bit-counter and a 4-bit-counter instance share stimulus,
// directed scenarios plus randomized traffic are checked against an event-count reference model.
module tb_commit_perf_monitor;

  localparam int DEPTH = 8;
  localparam int HLIM  = 16;
  localparam int S_IDLE = 0, S_RUN = 1, S_HUNG = 2;

  logic        clk = 1'b0;
  logic        rst, en, clr, vld, ctrl, mis, stall, pop;
  logic [31:0] pc;
  logic [2:0]  rd_addr;
  logic [31:0] rd32, tpc32, rd4, tpc4;
  logic        tvld32, tovf32, hang32, tvld4, tovf4, hang4;

  int n_cmp = 0;
  int n_bad = 0;

  longint      m_cyc, m_ret, m_ctrl, m_misp, m_stall;
  int          m_state, m_timer;
  bit          m_hang, m_ovf;
  logic [31:0] m_q[$];
  logic [31:0] m_rd32, m_rd4;

  always #5 clk = ~clk;

  commit_perf_monitor #(.CNT_W(32), .TRACE_DEPTH(DEPTH), .HANG_LIMIT(HLIM)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_clear(clr), .i_insn_vld(vld),
    .i_ctrl(ctrl), .i_mispred(mis), .i_pc(pc), .i_stall(stall), .i_rd_addr(rd_addr),
    .o_rd_data(rd32), .i_trace_pop(pop), .o_trace_vld(tvld32), .o_trace_pc(tpc32),
    .o_trace_ovf(tovf32), .o_hang(hang32));

  commit_perf_monitor #(.CNT_W(4), .TRACE_DEPTH(DEPTH), .HANG_LIMIT(HLIM)) u_sat (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_clear(clr), .i_insn_vld(vld),
    .i_ctrl(ctrl), .i_mispred(mis), .i_pc(pc), .i_stall(stall), .i_rd_addr(rd_addr),
    .o_rd_data(rd4), .i_trace_pop(pop), .o_trace_vld(tvld4), .o_trace_pc(tpc4),
    .o_trace_ovf(tovf4), .o_hang(hang4));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint x, input longint maxv);
    return (x > maxv) ? maxv : x;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a, input longint maxv);
    logic [31:0] s;
    s = 32'd0;
    case (a)
      3'd0: s = 32'(sat(m_cyc, maxv));
      3'd1: s = 32'(sat(m_ret, maxv));
      3'd2: s = 32'(sat(m_ctrl, maxv));
      3'd3: s = 32'(sat(m_misp, maxv));
      3'd4: s = 32'(sat(m_stall, maxv));
      3'd5: begin
        s[11:4] = 8'(m_q.size());
        s[3]    = m_ovf;
        s[2]    = m_hang;
        s[1:0]  = 2'(m_state);
      end
      default: s = 32'd0;
    endcase
    return s;
  endfunction

  task automatic model_clear();
    m_cyc = 0; m_ret = 0; m_ctrl = 0; m_misp = 0; m_stall = 0;
    m_state = S_IDLE; m_timer = 0; m_hang = 1'b0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  // Applies one clock edge of the rules to the model, using inputs as seen at that edge.
  task automatic model_step();
    bit counting, full, popped;
    if (!rst) begin
      model_clear();
      m_rd32 = 32'd0; m_rd4 = 32'd0;
      return;
    end
    m_rd32 = exp_rd(rd_addr, 64'h0000_0000_FFFF_FFFF);
    m_rd4  = exp_rd(rd_addr, 64'd15);
    if (clr) begin
      model_clear();
      return;
    end
    counting = en && (m_state != S_IDLE || vld);
    if (counting) begin
      m_cyc++;
      m_ret   += vld;
      m_ctrl  += (vld && ctrl);
      m_misp  += (vld && mis);
      m_stall += stall;
    end
    full   = (m_q.size() == DEPTH);
    popped = pop && (m_q.size() != 0);
    if (popped) void'(m_q.pop_front());
    if (counting && vld && mis) begin
      if (!full || popped) m_q.push_back(pc);
      else m_ovf = 1'b1;
    end
    if (m_state == S_IDLE) begin
      if (en && vld) begin m_state = S_RUN; m_timer = 0; end
    end else if (m_state == S_RUN) begin
      if (m_timer == HLIM) begin m_state = S_HUNG; m_hang = 1'b1; end
      else if (en) m_timer = vld ? 0 : m_timer + 1;
    end
  endtask

  task automatic check_all();
    logic [31:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 32'd0;
    check_val("rd32", rd32, m_rd32);
    check_val("rd4", rd4, m_rd4);
    check_val("tvld32", 32'(tvld32), 32'(m_q.size() != 0));
    check_val("tvld4", 32'(tvld4), 32'(m_q.size() != 0));
    check_val("tpc32", tpc32, head);
    check_val("tpc4", tpc4, head);
    check_val("tovf32", 32'(tovf32), 32'(m_ovf));
    check_val("tovf4", 32'(tovf4), 32'(m_ovf));
    check_val("hang32", 32'(hang32), 32'(m_hang));
    check_val("hang4", 32'(hang4), 32'(m_hang));
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic drive(input bit e, input bit c, input bit v, input bit ct, input bit mi,
                       input logic [31:0] p, input logic [2:0] a, input bit po);
    en = e; clr = c; vld = v; ctrl = ct; mis = mi; pc = p; rd_addr = a; pop = po;
    stall = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int p;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'd0, 3'd0, 0);
    model_clear();
    m_rd32 = 32'd0; m_rd4 = 32'd0;
    tick(2);
    check_val("reset_rd", rd32, 32'd0);
    rst = 1'b1;

    // 1: ten back-to-back retires
    drive(1, 0, 1, 0, 0, 32'h40, 3'd0, 0);
    tick(10);
    drive(0, 0, 0, 0, 0, 32'd0, 3'd0, 0); tick();
    check_val("t1_cycles", rd32, 32'd10);
    drive(0, 0, 0, 0, 0, 32'd0, 3'd1, 0); tick();
    check_val("t1_retired", rd32, 32'd10);
    drive(0, 0, 0, 0, 0, 32'd0, 3'd5, 0); tick();
    check_val("t1_status", rd32, 32'd1);
    check_val("t1_hang", 32'(hang32), 32'd0);

    // 2: three mispredicts drained in order
    drive(0, 1, 0, 0, 0, 32'd0, 3'd0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 1, 32'h100 + 32'(4 * i), 3'd0, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 32'd0, 3'd3, 0); tick();
    check_val("t2_mispred", rd32, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_val("t2_head", tpc32, 32'h100 + 32'(4 * i));
      drive(0, 0, 0, 0, 0, 32'd0, 3'd3, 1); tick();
    end
    check_val("t2_empty", 32'(tvld32), 32'd0);

    // 3: overflow, then full push+pop without overflow
    drive(0, 1, 0, 0, 0, 32'd0, 3'd0, 0); tick();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, 0, 1, 0, 1, 32'h200 + 32'(4 * i), 3'd0, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 32'd0, 3'd5, 0); tick();
    check_val("t3_status_ovf", rd32, 32'h89);
    check_val("t3_ovf", 32'(tovf32), 32'd1);
    drive(0, 1, 0, 0, 0, 32'd0, 3'd0, 0); tick();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, 0, 1, 0, 1, 32'h300 + 32'(4 * i), 3'd0, (i == DEPTH)); tick();
    end
    drive(0, 0, 0, 0, 0, 32'd0, 3'd5, 0); tick();
    check_val("t3_status_full", rd32, 32'h81);
    check_val("t3_no_ovf", 32'(tovf32), 32'd0);
    check_val("t3_head", tpc32, 32'h304);

    // 4: hang detection, stickiness and clear
    drive(0, 1, 0, 0, 0, 32'd0, 3'd0, 0); tick();
    drive(1, 0, 1, 0, 0, 32'h500, 3'd0, 0); tick();
    drive(1, 0, 0, 0, 0, 32'h0, 3'd0, 0); tick(HLIM);
    check_val("t4_not_yet", 32'(hang32), 32'd0);
    tick();
    check_val("t4_hang", 32'(hang32), 32'd1);
    drive(0, 0, 0, 0, 0, 32'd0, 3'd5, 0); tick();
    check_val("t4_status", rd32, 32'd6);
    drive(1, 0, 1, 0, 0, 32'h504, 3'd0, 0); tick();
    check_val("t4_sticky", 32'(hang32), 32'd1);
    drive(0, 1, 0, 0, 0, 32'd0, 3'd0, 0); tick();
    check_val("t4_cleared", 32'(hang32), 32'd0);
    drive(0, 0, 0, 0, 0, 32'd0, 3'd0, 0); tick();
    check_val("t4_cycles0", rd32, 32'd0);
    drive(0, 0, 0, 0, 0, 32'd0, 3'd5, 0); tick();
    check_val("t4_status0", rd32, 32'd0);

    // 5: saturation of the narrow counters
    drive(0, 1, 0, 0, 0, 32'd0, 3'd0, 0); tick();
    drive(1, 0, 1, 0, 0, 32'h600, 3'd0, 0); tick(20);
    drive(0, 0, 0, 0, 0, 32'd0, 3'd1, 0); tick();
    check_val("t5_sat4", rd4, 32'd15);
    check_val("t5_wide", rd32, 32'd20);

    // 6: async reset between edges, then clear racing a mispredict push
    drive(1, 0, 1, 0, 1, 32'h400, 3'd0, 0); tick(3);
    #3 rst = 1'b0;
    #1;
    check_val("arst_rd32", rd32, 32'd0);
    check_val("arst_rd4", rd4, 32'd0);
    check_val("arst_tvld", 32'(tvld32), 32'd0);
    check_val("arst_tpc", tpc32, 32'd0);
    check_val("arst_hang", 32'(hang32), 32'd0);
    model_clear();
    m_rd32 = 32'd0; m_rd4 = 32'd0;
    tick();
    rst = 1'b1;
    drive(1, 0, 1, 0, 1, 32'h500, 3'd0, 0); tick(2);
    drive(1, 1, 1, 0, 1, 32'h508, 3'd0, 0); tick();
    check_val("t6_fifo_empty", 32'(tvld32), 32'd0);
    drive(0, 0, 0, 0, 0, 32'd0, 3'd3, 0); tick();
    check_val("t6_mispred0", rd32, 32'd0);

    // Randomized traffic with varying retire density
    p = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) p = (c / 300 % 3 == 0) ? 5 : ((c / 300 % 3 == 1) ? 50 : 90);
      en    = ($urandom_range(0, 99) < 90);
      clr   = ($urandom_range(0, 199) == 0);
      vld   = ($urandom_range(0, 99) < p);
      ctrl  = 1'($urandom_range(0, 1));
      mis   = ($urandom_range(0, 99) < 40);
      stall = ($urandom_range(0, 99) < 30);
      pc    = $urandom;
      rd_addr = 3'($urandom_range(0, 7));
      pop   = ($urandom_range(0, 99) < 30);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
